// File: rtl/borrow_lookahead_sub_pipe_pkg.sv
// borrow_lookahead_sub_pipe_pkg: shared widths and depth for the pipelined borrow-lookahead subtractor
package borrow_lookahead_sub_pipe_pkg;
    localparam int N_DEFAULT  = 7;
    localparam int PIPE_DEPTH = 2;
    function automatic int gate_width(input int n);
        return 3 * (n + 1);
    endfunction
endpackage

// File: rtl/borrow_lookahead_logic.sv
// borrow_lookahead_logic: combinational borrow chain from generate/propagate, yields borrows, chain ANDs and difference
module borrow_lookahead_logic
    import borrow_lookahead_sub_pipe_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N:0] x,
    input  logic [N:0] g,
    input  logic [N:0] p,
    input  logic       bin,
    output logic [N:0] bout,
    output logic [N:0] ands,
    output logic [N:0] diff
);
    logic brw;
    always_comb begin
        brw  = bin;
        bout = '0;
        ands = '0;
        diff = '0;
        for (int i = 0; i <= N; i++) begin
            ands[i] = brw & p[i];
            diff[i] = x[i] ^ brw;
            brw     = g[i] | ands[i];
            bout[i] = brw;
        end
    end
endmodule

// File: rtl/borrow_lookahead_sub_pipe.sv
// borrow_lookahead_sub_pipe: two-stage valid/ready subtractor Diff = A - B - Bin with flags and gate-activity export
module borrow_lookahead_sub_pipe
    import borrow_lookahead_sub_pipe_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N:0]               A,
    input  logic [N:0]               B,
    input  logic                     Bin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N:0]               Diff,
    output logic [N:0]               Bout,
    output logic                     Ovf,
    output logic                     Zero,
    output logic [gate_width(N)-1:0] Gate
);
    logic       s1_valid, s2_valid, s2_load, accept;
    logic [N:0] s1_x, s1_g, s1_p;
    logic       s1_bin, s1_an, s1_bn;
    logic [N:0] chain_bout, chain_ands, chain_diff;

    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_bin   <= 1'b0;
            s1_an    <= 1'b0;
            s1_bn    <= 1'b0;
        end else begin
            if (accept) begin
                s1_x   <= A ^ B;
                s1_g   <= ~A & B;
                s1_p   <= ~(A ^ B);
                s1_bin <= Bin;
                s1_an  <= A[N];
                s1_bn  <= B[N];
            end
            s1_valid <= accept | (s1_valid & ~s2_load);
        end
    end

    borrow_lookahead_logic #(.N(N)) u_chain (
        .x    (s1_x),
        .g    (s1_g),
        .p    (s1_p),
        .bin  (s1_bin),
        .bout (chain_bout),
        .ands (chain_ands),
        .diff (chain_diff)
    );

    // Output registers only move on a stage-2 load, so they hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            Diff     <= '0;
            Bout     <= '0;
            Ovf      <= 1'b0;
            Zero     <= 1'b0;
            Gate     <= '0;
        end else begin
            if (s2_load) begin
                Diff <= chain_diff;
                Bout <= chain_bout;
                Ovf  <= (s1_an ^ s1_bn) & (chain_diff[N] ^ s1_an);
                Zero <= ~|chain_diff;
                Gate <= {s1_p, s1_g, chain_ands};
            end
            s2_valid <= s2_load | (s2_valid & ~out_ready);
        end
    end
endmodule

// File: tb/tb_borrow_lookahead_sub_pipe.sv
// tb_borrow_lookahead_sub_pipe: directed and randomized checks against an arithmetic reference model with a scoreboard
module tb_borrow_lookahead_sub_pipe;
    localparam int N = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N:0]   A = '0;
    logic [N:0]   B = '0;
    logic         Bin = 1'b0;
    logic         in_ready, out_valid, Ovf, Zero;
    logic [N:0]   Diff, Bout;
    logic [23:0]  Gate;

    typedef struct packed {
        logic [7:0]  diff;
        logic [7:0]  bout;
        logic        ovf;
        logic        zero;
        logic [23:0] gate;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int n_in = 0;
    int n_out = 0;

    borrow_lookahead_sub_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero),
        .Gate      (Gate)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        int ia, ib, ibin, d, m;
        logic [7:0] p, g, ands;
        logic bi;
        ia = int'(a);
        ib = int'(b);
        ibin = bin ? 1 : 0;
        d = ia - ib - ibin;
        e.diff = 8'(d);
        for (int i = 0; i < 8; i++) begin
            m = (1 << (i + 1)) - 1;
            e.bout[i] = (ia & m) < ((ib & m) + ibin);
        end
        e.ovf  = (a[7] != b[7]) && (e.diff[7] != a[7]);
        e.zero = (e.diff == 8'h00);
        p = ~(a ^ b);
        g = ~a & b;
        bi = bin;
        for (int i = 0; i < 8; i++) begin
            ands[i] = bi & p[i];
            bi = e.bout[i];
        end
        e.gate = {p, g, ands};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        #1;
        if (in_valid && in_ready) begin
            q.push_back(model(A, B, Bin));
            n_in++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            chk("sb_avail", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_diff", 32'(Diff), 32'(e.diff));
                chk("sb_bout", 32'(Bout), 32'(e.bout));
                chk("sb_ovf",  32'(Ovf),  32'(e.ovf));
                chk("sb_zero", 32'(Zero), 32'(e.zero));
                chk("sb_gate", 32'(Gate), 32'(e.gate));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic bi,
                            input logic [7:0] d, input logic b7, input logic ov, input logic z);
        A = a; B = b; Bin = bi; in_valid = 1'b1;
        tick();
        chk("lat_early", 32'(out_valid), 0);
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("dir_diff",  32'(Diff), 32'(d));
        chk("dir_bout7", 32'(Bout[N]), 32'(b7));
        chk("dir_ovf",   32'(Ovf), 32'(ov));
        chk("dir_zero",  32'(Zero), 32'(z));
        tick();
    endtask

    initial begin
        int sent0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_diff", 32'(Diff), 0);
        chk("rst_bout", 32'(Bout), 0);
        chk("rst_ovf",  32'(Ovf), 0);
        chk("rst_zero", 32'(Zero), 0);
        chk("rst_gate", 32'(Gate), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;

        directed(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        directed(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        directed(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        directed(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        directed(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        directed(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure: two beats fill the pipe, the third waits
        out_ready = 1'b0;
        A = 8'd10; B = 8'd1; Bin = 1'b0; in_valid = 1'b1;
        tick();
        A = 8'd20; B = 8'd2;
        tick();
        A = 8'd30; B = 8'd3;
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_diff", 32'(Diff), 32'h09);
        tick();
        chk("bp_hold_diff", 32'(Diff), 32'h09);
        chk("bp_hold_ready", 32'(in_ready), 0);
        tick();
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        chk("bp_out0", 32'(Diff), 32'h09);
        tick();
        in_valid = 1'b0;
        chk("bp_valid1", 32'(out_valid), 1);
        chk("bp_out1", 32'(Diff), 32'h12);
        tick();
        chk("bp_valid2", 32'(out_valid), 1);
        chk("bp_out2", 32'(Diff), 32'h1B);
        tick();
        chk("bp_empty", 32'(out_valid), 0);

        // Random streaming with random valid/ready
        sent0 = n_in;
        for (int c = 0; c < 5000 && (n_in - sent0) < 256; c++) begin
            in_valid  = 1'($urandom);
            A         = 8'($urandom);
            B         = 8'($urandom);
            Bin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("rand_sent", 32'(n_in - sent0), 256);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) tick();
        chk("drain_empty", 32'(q.size()), 0);
        chk("count_in_out", 32'(n_out), 32'(n_in));
        chk("drain_valid", 32'(out_valid), 0);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        A = 8'($urandom); B = 8'($urandom);
        tick();
        A = 8'($urandom); B = 8'($urandom);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_diff", 32'(Diff), 0);
        chk("async_rst_gate", 32'(Gate), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("no_stale", 32'(out_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/borrow_lookahead_sub_pipe.md
Name: borrow_lookahead_sub_pipe

Overview:
Two-stage pipelined (N+1)-bit subtractor computing Diff = A - B - Bin with a borrow-lookahead chain. It is the subtract-direction counterpart of the team's carry-lookahead adder logic. It sits in the convolution datapath wherever operands are differenced, with valid/ready handshakes on both sides and full throughput. It also exports a per-stage gate-activity vector for power tests.

Parameters:
N, 7, MSB index; operand width is N+1 bits.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
A  in  N+1  minuend, unsigned/two's complement
B  in  N+1  subtrahend
Bin  in  1  borrow in
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
Diff  out  N+1  A - B - Bin mod 2^(N+1)
Bout  out  N+1  per-bit borrow chain; Bout[N] = unsigned borrow out
Ovf  out  1  signed overflow
Zero  out  1  Diff == 0
Gate  out  3*(N+1)  {P, G, Ands} of the stage-2 chain, for power test

Behaviour:
- Reset: one clock, reset asynchronous and active-low (rst_n). Asserting it clears s1_valid and s2_valid, so out_valid=0. Diff, Bout, Ovf, Zero and Gate go to 0; in_ready=1 combinationally once reset is released. Reset mid-operation drops all in-flight beats and emits no partial output.
- Stage 1 (accept): on in_valid & in_ready, register X=A^B, G=~A&B, P=~(A^B), Bin, and sign bits A[N], B[N]. Set s1_valid=1.
- Stage 2 (resolve): when s1_valid and stage 2 can load, compute borrows:
  - Ands[0] = Bin & P[0]; Bout[0] = G[0] | Ands[0]
  - Ands[i] = Bout[i-1] & P[i]; Bout[i] = G[i] | Ands[i]
  - Diff[i] = X[i] ^ (i==0 ? Bin : Bout[i-1])
  - Ovf = (A[N] ^ B[N]) & (Diff[N] ^ A[N]); Zero = ~|Diff
  - Register all of these and set s2_valid=1.
- Handshakes:
  - s2_load = s1_valid & (~s2_valid | out_ready)
  - in_ready = ~s1_valid | s2_load
  - out_valid = s2_valid
  - s2_valid clears when out_valid & out_ready & ~s2_load.
  - s1_valid clears when s2_load & ~(in_valid & in_ready).
- Latency: beat accepted in cycle t appears as out_valid in cycle t+2 with no stalls. Throughput is 1 beat/cycle.
- Backpressure: while out_ready=0, Diff, Bout, Ovf, Zero and Gate hold stable with out_valid=1. Stage 1 may hold one more beat; then in_ready=0. Capacity is 2 beats. Order is preserved with no drop or duplicate.
- Simultaneous events:
  - Accept and stage-2 load in the same cycle are legal (pipeline advance).
  - Output handshake and new load in the same cycle keep s2_valid=1 with the new data.
- Wrap-around: arithmetic is modulo 2^(N+1). 0 - 1 gives all-ones with Bout[N]=1.
- Inputs are sampled only on an accept. A, B and Bin are don't-care otherwise.
- Gate updates only on s2_load; it holds otherwise.

Decomposition:
- Shared package/header: default width constant, Gate width formula 3*(N+1), and a localparam for pipeline depth (2).
- Sub-module: borrow_lookahead_logic. It is purely combinational: (X, G, P, Bin) -> (Bout, Ands). It mirrors the carry chain with inverted generate/propagate.
- The top level holds the stage registers, handshake logic, and flag computation.

Test Plan:
- N=7, A=0x05, B=0x03, Bin=0, out_ready=1 -> two cycles later Diff=0x02, Bout[7]=0, Ovf=0, Zero=0.
- A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout[7]=1, Ovf=0. Then A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout[7]=1.
- Signed overflow:
  - A=0x80, B=0x01 -> Diff=0x7F, Ovf=1.
  - A=0x7F, B=0xFF -> Diff=0x80, Ovf=1.
  - A=B=0x5A -> Diff=0x00, Zero=1, Ovf=0.
- Backpressure:
  - Drive beats (10-1), (20-2), (30-3) back-to-back with out_ready=0 -> in_ready falls after 2 accepts; out_valid=1 holding Diff=0x09 stable.
  - Then raise out_ready -> outputs 0x09, 0x12, 0x1B in order, one per cycle, with no gaps.
- Streaming: 256 random beats with random in_valid/out_ready -> scoreboard matches A-B-Bin, and the count in equals the count out.
- Reset: assert rst_n=0 asynchronously (off clock edge) with 2 beats in flight -> out_valid=0 and Diff=0 immediately. After release, in_ready=1 and no stale beat ever emerges.
